mem1p_arb_ctl: RTL and testbench

- Sequences one single-port synchronous RAM (depth × width, one shared address) and shares it between a write-request channel and a read-request channel.
- Grants at most one access per cycle, using round-robin when both channels request.
- Captures read data exactly one cycle after issue, before a later write can disturb it, and returns it on an srdy/drdy read-response channel with full throughput.
- Sits between client logic and the RAM instance; the RAM's output mux follows a held read address, so read data is valid only in the cycle after issue.

---
 rtl/mem1p_ctl_pkg.sv | 22 ++
 rtl/mem1p_rsp_buf.sv | 64 ++++++
 rtl/mem1p_arb_ctl.sv | 104 ++++++++++
 tb/tb_mem1p_arb_ctl.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem1p_ctl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mem1p_ctl_pkg
// Purpose  : Shared constants and grant encoding for the single-port RAM
//            arbiter/controller and its response buffer.
// Revision : 1.0 - initial release
// ============================================================================
package mem1p_ctl_pkg;

    localparam logic RR_WR = 1'b0;
    localparam logic RR_RD = 1'b1;

    localparam int RSP_DEPTH = 2;

    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_WR   = 2'd1,
        GNT_RD   = 2'd2
    } gnt_e;

endpackage
`default_nettype wire

// File: rtl/mem1p_rsp_buf.sv
`default_nettype none
// ============================================================================
// Module   : mem1p_rsp_buf
// Purpose  : Two-entry srdy/drdy FIFO holding captured read data; exposes its
//            occupancy so the arbiter can ration read credits.
// Revision : 1.0 - initial release
// ============================================================================
module mem1p_rsp_buf
    import mem1p_ctl_pkg::*;
#(
    parameter int width = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             push,
    input  logic [width-1:0] push_data,
    output logic             srdy,
    input  logic             drdy,
    output logic [width-1:0] data,
    output logic [1:0]       count
);

    localparam logic [1:0] c_full = 2'(RSP_DEPTH);

    logic [width-1:0] r_mem [RSP_DEPTH];
    logic             r_wr_ptr;
    logic             r_rd_ptr;
    logic [1:0]       r_count;

    logic             w_pop;
    logic             w_push_ok;

    assign srdy  = (r_count != 2'd0);
    assign data  = r_mem[r_rd_ptr];
    assign count = r_count;

    assign w_pop     = srdy && drdy;
    // A pop frees the head slot at the same edge, so a full buffer can still take a push.
    assign w_push_ok = push && ((r_count != c_full) || w_pop);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            r_count <= r_count + 2'(w_push_ok) - 2'(w_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= push_data;
        end
    end

endmodule
`default_nettype wire

// File: rtl/mem1p_arb_ctl.sv
`default_nettype none
// ============================================================================
// Module   : mem1p_arb_ctl
// Purpose  : Shares one single-port synchronous RAM between a write channel and
//            a read channel with round-robin arbitration and a credited,
//            full-throughput read-response path.
// Revision : 1.0 - initial release
// ============================================================================
module mem1p_arb_ctl
    import mem1p_ctl_pkg::*;
#(
    parameter int depth   = 256,
    parameter int width   = 8,
    parameter int addr_sz = $clog2(depth)
) (
    input  logic               clk,
    input  logic               reset_n,

    input  logic               wr_srdy,
    output logic               wr_drdy,
    input  logic [addr_sz-1:0] wr_addr,
    input  logic [width-1:0]   wr_data,

    input  logic               rq_srdy,
    output logic               rq_drdy,
    input  logic [addr_sz-1:0] rq_addr,

    output logic               rs_srdy,
    input  logic               rs_drdy,
    output logic [width-1:0]   rs_data,

    output logic               m_wr_en,
    output logic               m_rd_en,
    output logic [addr_sz-1:0] m_addr,
    output logic [width-1:0]   m_d_in,
    input  logic [width-1:0]   m_d_out
);

    logic       r_rr_ptr;
    logic       r_inflight;

    logic [1:0] w_buf_count;
    logic       w_pop;
    logic [2:0] w_credit;
    logic       w_rd_ok;
    logic       w_both_req;
    gnt_e       w_gnt;

    // Slots already claimed by buffered or in-flight data; a pop this cycle
    // returns one, which keeps back-to-back reads bubble-free.
    assign w_pop      = rs_srdy && rs_drdy;
    assign w_credit   = 3'(w_buf_count) + 3'(r_inflight) - 3'(w_pop);
    assign w_rd_ok    = (w_credit < 3'(RSP_DEPTH));
    assign w_both_req = wr_srdy && rq_srdy;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rr_ptr   <= RR_WR;
            r_inflight <= 1'b0;
        end else begin
            // A write is always grantable, so both requesting implies a grant.
            if (w_both_req) begin
                r_rr_ptr <= ~r_rr_ptr;
            end
            r_inflight <= (w_gnt == GNT_RD);
        end
    end

    always_comb begin
        w_gnt = GNT_NONE;
        if (w_both_req && w_rd_ok) begin
            w_gnt = (r_rr_ptr == RR_RD) ? GNT_RD : GNT_WR;
        end else if (wr_srdy) begin
            w_gnt = GNT_WR;
        end else if (rq_srdy && w_rd_ok) begin
            w_gnt = GNT_RD;
        end
    end

    always_comb begin
        wr_drdy = (w_gnt == GNT_WR);
        rq_drdy = (w_gnt == GNT_RD);
        m_wr_en = (w_gnt == GNT_WR);
        m_rd_en = (w_gnt == GNT_RD);
        m_addr  = (w_gnt == GNT_WR) ? wr_addr : rq_addr;
        m_d_in  = wr_data;
    end

    // RAM output is only valid in the cycle after issue, so capture it unconditionally then.
    mem1p_rsp_buf #(
        .width (width)
    ) u_rsp_buf (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (r_inflight),
        .push_data (m_d_out),
        .srdy      (rs_srdy),
        .drdy      (rs_drdy),
        .data      (rs_data),
        .count     (w_buf_count)
    );

endmodule
`default_nettype wire

// File: tb/tb_mem1p_arb_ctl.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem1p_arb_ctl
// Purpose  : Directed self-checking bench for mem1p_arb_ctl with a behavioural
//            single-port RAM whose read data follows a registered address.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem1p_arb_ctl;

    logic       clk;
    logic       reset_n;
    logic       wr_srdy, wr_drdy;
    logic [7:0] wr_addr, wr_data;
    logic       rq_srdy, rq_drdy;
    logic [7:0] rq_addr;
    logic       rs_srdy, rs_drdy;
    logic [7:0] rs_data;
    logic       m_wr_en, m_rd_en;
    logic [7:0] m_addr, m_d_in, m_d_out;

    int n_cmp = 0;
    int n_err = 0;

    mem1p_arb_ctl #(.depth(256), .width(8)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .wr_srdy (wr_srdy),
        .wr_drdy (wr_drdy),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .rq_srdy (rq_srdy),
        .rq_drdy (rq_drdy),
        .rq_addr (rq_addr),
        .rs_srdy (rs_srdy),
        .rs_drdy (rs_drdy),
        .rs_data (rs_data),
        .m_wr_en (m_wr_en),
        .m_rd_en (m_rd_en),
        .m_addr  (m_addr),
        .m_d_in  (m_d_in),
        .m_d_out (m_d_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single-port RAM: write and address register on the edge, output follows held address.
    logic [7:0] ram [256];
    logic [7:0] ram_ra;
    always @(posedge clk) begin
        if (m_wr_en) ram[m_addr] <= m_d_in;
        if (m_rd_en) ram_ra <= m_addr;
    end
    assign m_d_out = ram[ram_ra];

    // Response buffer must never be pushed while full without a simultaneous pop.
    always @(negedge clk) begin
        if (reset_n && dut.r_inflight) begin
            n_cmp++;
            if (dut.w_buf_count == 2'd2 && !(rs_srdy && rs_drdy)) begin
                n_err++;
                $display("FAIL overflow: push into full buffer, count=%0d", dut.w_buf_count);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [7:0] a, input logic [7:0] d);
        bit got = 0;
        wr_srdy = 1'b1; wr_addr = a; wr_data = d;
        #1;
        for (int k = 0; k < 20 && !got; k++) begin
            if (wr_drdy) got = 1;
            tick();
        end
        wr_srdy = 1'b0;
        n_cmp++;
        if (!got) begin
            n_err++;
            $display("FAIL write_accept: addr %h never accepted, got 0 expected 1", a);
        end
    endtask

    task automatic do_read(input logic [7:0] a, output logic [7:0] d);
        bit got = 0;
        d = 8'hxx;
        rq_srdy = 1'b1; rq_addr = a; rs_drdy = 1'b1;
        #1;
        for (int k = 0; k < 20 && !got; k++) begin
            if (rq_drdy) got = 1;
            tick();
        end
        rq_srdy = 1'b0;
        got = 0;
        for (int k = 0; k < 20 && !got; k++) begin
            if (rs_srdy) begin
                got = 1;
                d = rs_data;
            end
            tick();
        end
        n_cmp++;
        if (!got) begin
            n_err++;
            $display("FAIL read_timeout: addr %h no response, got 0 expected 1", a);
        end
    endtask

    task automatic test_reset();
        #2 reset_n = 1'b0;
        tick(); tick();
        n_cmp++; if (rs_srdy !== 1'b0) begin n_err++; $display("FAIL reset_rs_srdy: got %b expected 0", rs_srdy); end
        n_cmp++; if (m_wr_en !== 1'b0) begin n_err++; $display("FAIL reset_m_wr_en: got %b expected 0", m_wr_en); end
        n_cmp++; if (m_rd_en !== 1'b0) begin n_err++; $display("FAIL reset_m_rd_en: got %b expected 0", m_rd_en); end
        reset_n = 1'b1;
        tick();
        // Both request: the pointer starts on the write side.
        wr_srdy = 1'b1; wr_addr = 8'hF0; wr_data = 8'h00;
        rq_srdy = 1'b1; rq_addr = 8'hF0; rs_drdy = 1'b1;
        #1;
        n_cmp++; if (wr_drdy !== 1'b1) begin n_err++; $display("FAIL reset_rr_wr: got %b expected 1", wr_drdy); end
        n_cmp++; if (rq_drdy !== 1'b0) begin n_err++; $display("FAIL reset_rr_rd: got %b expected 0", rq_drdy); end
        wr_srdy = 1'b0; rq_srdy = 1'b0;
        reset_n = 1'b0;
        #1 reset_n = 1'b1;
        tick();
    endtask

    task automatic test_write_read();
        do_write(8'h10, 8'hA5);
        rs_drdy = 1'b1; rq_srdy = 1'b1; rq_addr = 8'h10;
        #1;
        n_cmp++; if (rq_drdy !== 1'b1) begin n_err++; $display("FAIL wr_rd_accept: got %b expected 1", rq_drdy); end
        tick();
        rq_srdy = 1'b0;
        n_cmp++; if (rs_srdy !== 1'b0) begin n_err++; $display("FAIL wr_rd_lat1: got %b expected 0", rs_srdy); end
        tick();
        n_cmp++; if (rs_srdy !== 1'b1) begin n_err++; $display("FAIL wr_rd_lat2: got %b expected 1", rs_srdy); end
        n_cmp++; if (rs_data !== 8'hA5) begin n_err++; $display("FAIL wr_rd_data: got %h expected a5", rs_data); end
        tick();
        n_cmp++; if (rs_srdy !== 1'b0) begin n_err++; $display("FAIL wr_rd_drain: got %b expected 0", rs_srdy); end
    endtask

    task automatic test_simultaneous();
        wr_srdy = 1'b1; wr_addr = 8'h31; wr_data = 8'h5A;
        rq_srdy = 1'b1; rq_addr = 8'h10; rs_drdy = 1'b1;
        for (int c = 0; c < 4; c++) begin
            #1;
            n_cmp++; if (wr_drdy !== (c % 2 == 0)) begin n_err++; $display("FAIL simul_wr_c%0d: got %b expected %b", c, wr_drdy, (c % 2 == 0)); end
            n_cmp++; if (rq_drdy !== (c % 2 == 1)) begin n_err++; $display("FAIL simul_rd_c%0d: got %b expected %b", c, rq_drdy, (c % 2 == 1)); end
            n_cmp++; if (m_wr_en && m_rd_en) begin n_err++; $display("FAIL simul_both_en_c%0d: got 11 expected not both", c); end
            n_cmp++; if (m_addr !== ((c % 2 == 0) ? 8'h31 : 8'h10)) begin n_err++; $display("FAIL simul_addr_c%0d: got %h", c, m_addr); end
            tick();
        end
        wr_srdy = 1'b0; rq_srdy = 1'b0;
        tick(); tick(); tick();
    endtask

    task automatic test_backpressure();
        do_write(8'h01, 8'h61);
        do_write(8'h02, 8'h62);
        do_write(8'h03, 8'h63);
        rs_drdy = 1'b0; rq_srdy = 1'b1; rq_addr = 8'h01;
        #1;
        n_cmp++; if (rq_drdy !== 1'b1) begin n_err++; $display("FAIL bp_acc1: got %b expected 1", rq_drdy); end
        tick();
        rq_addr = 8'h02;
        #1;
        n_cmp++; if (rq_drdy !== 1'b1) begin n_err++; $display("FAIL bp_acc2: got %b expected 1", rq_drdy); end
        tick();
        rq_addr = 8'h03;
        for (int c = 0; c < 4; c++) begin
            #1;
            n_cmp++; if (rq_drdy !== 1'b0) begin n_err++; $display("FAIL bp_stall_c%0d: got %b expected 0", c, rq_drdy); end
            tick();
        end
        n_cmp++; if (rs_data !== 8'h61) begin n_err++; $display("FAIL bp_head: got %h expected 61", rs_data); end
        rs_drdy = 1'b1;
        #1;
        n_cmp++; if (rq_drdy !== 1'b1) begin n_err++; $display("FAIL bp_acc3: got %b expected 1", rq_drdy); end
        tick();
        rq_srdy = 1'b0;
        n_cmp++; if (rs_srdy !== 1'b1 || rs_data !== 8'h62) begin n_err++; $display("FAIL bp_rsp2: got %b/%h expected 1/62", rs_srdy, rs_data); end
        tick();
        n_cmp++; if (rs_srdy !== 1'b1 || rs_data !== 8'h63) begin n_err++; $display("FAIL bp_rsp3: got %b/%h expected 1/63", rs_srdy, rs_data); end
        tick();
        n_cmp++; if (rs_srdy !== 1'b0) begin n_err++; $display("FAIL bp_drain: got %b expected 0", rs_srdy); end
    endtask

    task automatic test_capture_hazard();
        logic [7:0] d;
        do_write(8'h05, 8'h11);
        rs_drdy = 1'b1; rq_srdy = 1'b1; rq_addr = 8'h05;
        #1;
        n_cmp++; if (rq_drdy !== 1'b1) begin n_err++; $display("FAIL haz_rd_acc: got %b expected 1", rq_drdy); end
        tick();
        rq_srdy = 1'b0;
        wr_srdy = 1'b1; wr_addr = 8'h05; wr_data = 8'h22;
        #1;
        n_cmp++; if (wr_drdy !== 1'b1) begin n_err++; $display("FAIL haz_wr_acc: got %b expected 1", wr_drdy); end
        tick();
        wr_srdy = 1'b0;
        n_cmp++; if (rs_srdy !== 1'b1 || rs_data !== 8'h11) begin n_err++; $display("FAIL haz_old: got %b/%h expected 1/11", rs_srdy, rs_data); end
        tick();
        do_read(8'h05, d);
        n_cmp++; if (d !== 8'h22) begin n_err++; $display("FAIL haz_new: got %h expected 22", d); end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 16; i++) do_write(8'h20 + 8'(i), 8'h80 + 8'(i));
        rs_drdy = 1'b1;
        for (int c = 0; c < 18; c++) begin
            rq_srdy = (c < 16);
            rq_addr = 8'h20 + 8'(c);
            #1;
            if (c < 16) begin
                n_cmp++; if (rq_drdy !== 1'b1) begin n_err++; $display("FAIL stream_acc_%0d: got %b expected 1", c, rq_drdy); end
            end
            if (c >= 2) begin
                n_cmp++;
                if (rs_srdy !== 1'b1 || rs_data !== 8'h80 + 8'(c - 2)) begin
                    n_err++; $display("FAIL stream_rsp_%0d: got %b/%h expected 1/%h", c - 2, rs_srdy, rs_data, 8'h80 + 8'(c - 2));
                end
            end
            tick();
        end
        rq_srdy = 1'b0;
        n_cmp++; if (rs_srdy !== 1'b0) begin n_err++; $display("FAIL stream_drain: got %b expected 0", rs_srdy); end
    endtask

    task automatic test_async_reset();
        rs_drdy = 1'b0; rq_srdy = 1'b1; rq_addr = 8'h01;
        tick(); tick();
        rq_srdy = 1'b0;
        n_cmp++; if (rs_srdy !== 1'b1) begin n_err++; $display("FAIL ar_pre: got %b expected 1", rs_srdy); end
        #2 reset_n = 1'b0;
        #1;
        n_cmp++; if (rs_srdy !== 1'b0) begin n_err++; $display("FAIL ar_immediate: got %b expected 0", rs_srdy); end
        tick(); tick();
        reset_n = 1'b1;
        rs_drdy = 1'b1;
        for (int c = 0; c < 3; c++) begin
            #1;
            n_cmp++; if (rs_srdy !== 1'b0) begin n_err++; $display("FAIL ar_stale_c%0d: got %b expected 0", c, rs_srdy); end
            tick();
        end
        wr_srdy = 1'b1; wr_addr = 8'h40; wr_data = 8'h77;
        rq_srdy = 1'b1; rq_addr = 8'h05;
        #1;
        n_cmp++; if (wr_drdy !== 1'b1 || rq_drdy !== 1'b0) begin n_err++; $display("FAIL ar_favour_wr: got %b%b expected 10", wr_drdy, rq_drdy); end
        tick();
        n_cmp++; if (wr_drdy !== 1'b0 || rq_drdy !== 1'b1) begin n_err++; $display("FAIL ar_then_rd: got %b%b expected 01", wr_drdy, rq_drdy); end
        tick();
        wr_srdy = 1'b0; rq_srdy = 1'b0;
        n_cmp++; if (rs_srdy !== 1'b0) begin n_err++; $display("FAIL ar_rsp_lat: got %b expected 0", rs_srdy); end
        tick();
        n_cmp++; if (rs_srdy !== 1'b1 || rs_data !== 8'h22) begin n_err++; $display("FAIL ar_ram_kept: got %b/%h expected 1/22", rs_srdy, rs_data); end
        tick();
    endtask

    initial begin
        reset_n = 1'b1;
        wr_srdy = 1'b0; wr_addr = 8'h00; wr_data = 8'h00;
        rq_srdy = 1'b0; rq_addr = 8'h00; rs_drdy = 1'b0;
        test_reset();
        test_write_read();
        test_simultaneous();
        test_backpressure();
        test_capture_hazard();
        test_back_to_back();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
